// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection and operand forwarding.
// Build option: define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB operand
// forwarding with load-use stalls only. Left undefined, there is no forwarding,
// and decode stalls on any in-flight writer of a used source register.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rv1,
  input  logic [31:0] id_rv2,
  input  logic        flush,
  input  logic        exm_we,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rv1,
  output logic [31:0] ex_rv2,
  output logic        id_stall
);

  localparam logic [6:0]  OpOp    = 7'b0110011;
  localparam logic [6:0]  OpImm   = 7'b0010011;
  localparam logic [6:0]  OpLoad  = 7'b0000011;
  localparam logic [6:0]  OpStore = 7'b0100011;
  localparam logic [6:0]  OpBr    = 7'b1100011;
  localparam logic [6:0]  OpJalr  = 7'b1100111;
  localparam logic [6:0]  OpJal   = 7'b1101111;
  localparam logic [6:0]  OpLui   = 7'b0110111;
  localparam logic [6:0]  OpAuipc = 7'b0010111;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OpOp) || (op == OpImm) || (op == OpLoad) || (op == OpStore) ||
           (op == OpBr) || (op == OpJalr);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OpOp) || (op == OpStore) || (op == OpBr);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OpOp) || (op == OpImm) || (op == OpLoad) || (op == OpLui) ||
           (op == OpAuipc) || (op == OpJal) || (op == OpJalr);
  endfunction

  logic        ex_valid_q;
  logic [31:0] ex_instr_q;
  logic [31:0] ex_pc_q;
  logic [31:0] ex_rv1_q;
  logic [31:0] ex_rv2_q;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use1;
  logic        id_use2;
  logic [4:0]  ex_rd;
  logic        hazard;
  logic        capture;

  assign id_rs1  = id_instr[19:15];
  assign id_rs2  = id_instr[24:20];
  // x0 is never a real dependency, so it is folded into the "used" flags.
  assign id_use1 = uses_rs1(id_instr[6:0]) && (id_rs1 != 5'd0);
  assign id_use2 = uses_rs2(id_instr[6:0]) && (id_rs2 != 5'd0);
  assign ex_rd   = ex_instr_q[11:7];

`ifdef ID_EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid_q && (ex_instr_q[6:0] == OpLoad) && id_valid && (ex_rd != 5'd0)) begin
      hazard = (id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd));
    end
  end
`else
  logic ex_writes;
  logic hit1;
  logic hit2;
  logic unused_fwd_data;

  assign ex_writes       = ex_valid_q && writes_rd(ex_instr_q[6:0]);
  assign unused_fwd_data = ^{exm_result, wb_data};

  // Without bypassing, any writer still in flight blocks decode until it retires.
  always_comb begin
    hit1   = (ex_writes && (ex_rd == id_rs1)) || (exm_we && (exm_rd == id_rs1)) ||
             (wb_we && (wb_rd == id_rs1));
    hit2   = (ex_writes && (ex_rd == id_rs2)) || (exm_we && (exm_rd == id_rs2)) ||
             (wb_we && (wb_rd == id_rs2));
    hazard = id_valid && ((id_use1 && hit1) || (id_use2 && hit2));
  end
`endif

  // Stall request and capture decision; flush and reset both win over a stall.
  always_comb begin
    id_stall = hazard && !flush && !reset;
    capture  = id_valid && !flush && !hazard;
  end

  // Pipeline register: capture the decoded instruction or load a bubble.
  always_ff @(posedge clk) begin
    if (reset || !capture) begin
      ex_valid_q <= 1'b0;
      ex_instr_q <= Nop;
      ex_pc_q    <= 32'd0;
      ex_rv1_q   <= 32'd0;
      ex_rv2_q   <= 32'd0;
    end else begin
      ex_valid_q <= 1'b1;
      ex_instr_q <= id_instr;
      ex_pc_q    <= id_pc;
      ex_rv1_q   <= id_rv1;
      ex_rv2_q   <= id_rv2;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_instr = ex_instr_q;
  assign ex_pc    = ex_pc_q;

`ifdef ID_EX_FORWARDING_EN
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic       ex_use1;
  logic       ex_use2;

  assign ex_rs1  = ex_instr_q[19:15];
  assign ex_rs2  = ex_instr_q[24:20];
  assign ex_use1 = ex_valid_q && uses_rs1(ex_instr_q[6:0]) && (ex_rs1 != 5'd0);
  assign ex_use2 = ex_valid_q && uses_rs2(ex_instr_q[6:0]) && (ex_rs2 != 5'd0);

  // Operand bypass: the younger EX/MEM result beats the older MEM/WB data.
  always_comb begin
    ex_rv1 = ex_valid_q ? ex_rv1_q : 32'd0;
    ex_rv2 = ex_valid_q ? ex_rv2_q : 32'd0;
    if (ex_use1 && exm_we && (exm_rd == ex_rs1)) begin
      ex_rv1 = exm_result;
    end else if (ex_use1 && wb_we && (wb_rd == ex_rs1)) begin
      ex_rv1 = wb_data;
    end
    if (ex_use2 && exm_we && (exm_rd == ex_rs2)) begin
      ex_rv2 = exm_result;
    end else if (ex_use2 && wb_we && (wb_rd == ex_rs2)) begin
      ex_rv2 = wb_data;
    end
  end
`else
  // No bypass: operands come straight from the register (zero for bubbles).
  always_comb begin
    ex_rv1 = ex_rv1_q;
    ex_rv2 = ex_rv2_q;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a vector table plus hand-written
// multi-cycle sequences for load-use, stall-until-clear, bypass and reset.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] AddX3  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] AddiX5 = 32'h0010_0293; // addi x5,x0,1
  localparam logic [31:0] LuiX7  = 32'h1234_53B7; // lui  x7,0x12345 (rs1 field = 8)
  localparam logic [31:0] SwX2   = 32'h0020_A023; // sw   x2,0(x1)
  localparam logic [31:0] JalX1  = 32'h0080_00EF; // jal  x1,8 (rs2 field = 8)
  localparam logic [31:0] LwX5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] SubX6  = 32'h4012_8333; // sub  x6,x5,x1
  localparam logic [31:0] AddX4a = 32'h0021_8233; // add  x4,x3,x2
  localparam logic [31:0] AddX4b = 32'h0031_8233; // add  x4,x3,x3

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_rv1, id_rv2;
  logic        flush;
  logic        exm_we;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_pc, ex_rv1, ex_rv2;
  logic        id_stall;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_rv1     (id_rv1),
    .id_rv2     (id_rv2),
    .flush      (flush),
    .exm_we     (exm_we),
    .exm_rd     (exm_rd),
    .exm_result (exm_result),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_instr   (ex_instr),
    .ex_pc      (ex_pc),
    .ex_rv1     (ex_rv1),
    .ex_rv2     (ex_rv2),
    .id_stall   (id_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        id_valid;
    logic [31:0] instr;
    logic        flush;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        exp_stall;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_rv1;
    logic [31:0] exp_rv2;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] ins,
                              input logic fl, input logic ew, input logic [4:0] er,
                              input logic ww, input logic [4:0] wr, input logic st,
                              input logic cap);
    vec_t r;
    r.name      = n;
    r.id_valid  = v;
    r.instr     = ins;
    r.flush     = fl;
    r.exm_we    = ew;
    r.exm_rd    = er;
    r.wb_we     = ww;
    r.wb_rd     = wr;
    r.exp_stall = st;
    r.exp_valid = cap;
    r.exp_instr = cap ? ins : Nop;
    r.exp_pc    = cap ? 32'h0000_0100 : 32'd0;
    r.exp_rv1   = cap ? 32'd5 : 32'd0;
    r.exp_rv2   = cap ? 32'd7 : 32'd0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_instr = Nop; id_pc = 32'd0; id_rv1 = 32'd0; id_rv2 = 32'd0;
    flush = 1'b0; exm_we = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
    id_valid = 1'b1; id_instr = ins; id_pc = pc; id_rv1 = r1; id_rv2 = r2;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    vecs[0]  = mk("add_plain",   1, AddX3,  0, 0, 0, 0, 0, 0,    1);
    vecs[1]  = mk("id_invalid",  0, AddX3,  0, 1, 1, 0, 0, 0,    0);
    vecs[2]  = mk("flush",       1, AddX3,  1, 0, 0, 0, 0, 0,    0);
    vecs[3]  = mk("exm_rs1",     1, AddX3,  0, 1, 1, 0, 0, !Fwd, Fwd);
    vecs[4]  = mk("wb_rs2",      1, AddX3,  0, 0, 0, 1, 2, !Fwd, Fwd);
    vecs[5]  = mk("exm_we_off",  1, AddX3,  0, 0, 1, 0, 0, 0,    1);
    vecs[6]  = mk("addi_x0",     1, AddiX5, 0, 1, 0, 1, 1, 0,    1);
    vecs[7]  = mk("lui_no_rs",   1, LuiX7,  0, 1, 8, 1, 8, 0,    1);
    vecs[8]  = mk("sw_rs2",      1, SwX2,   0, 0, 0, 1, 2, !Fwd, Fwd);
    vecs[9]  = mk("jal_no_rs",   1, JalX1,  0, 1, 8, 1, 0, 0,    1);
    vecs[10] = mk("flush_haz",   1, AddX3,  1, 1, 1, 1, 2, 0,    0);

    // Reset state, with reset still asserted for the stall read.
    step();
    check("rst_stall", id_stall, 0);
    check("rst_valid", ex_valid, 0);
    check("rst_instr", ex_instr, Nop);
    check("rst_pc",    ex_pc,    0);
    check("rst_rv1",   ex_rv1,   0);
    check("rst_rv2",   ex_rv2,   0);
    reset = 1'b0;

    // Single-cycle vectors, each starting from an empty EX stage.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      id_valid = vecs[i].id_valid; id_instr = vecs[i].instr; id_pc = 32'h0000_0100;
      id_rv1 = 32'd5; id_rv2 = 32'd7; flush = vecs[i].flush;
      exm_we = vecs[i].exm_we; exm_rd = vecs[i].exm_rd; exm_result = 32'hDEAD_0001;
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = 32'hDEAD_0002;
      #1;
      check({vecs[i].name, ".stall"}, id_stall, vecs[i].exp_stall);
      step();
      idle_inputs();
      #1;
      check({vecs[i].name, ".valid"}, ex_valid, vecs[i].exp_valid);
      check({vecs[i].name, ".instr"}, ex_instr, vecs[i].exp_instr);
      check({vecs[i].name, ".pc"},    ex_pc,    vecs[i].exp_pc);
      check({vecs[i].name, ".rv1"},   ex_rv1,   vecs[i].exp_rv1);
      check({vecs[i].name, ".rv2"},   ex_rv2,   vecs[i].exp_rv2);
    end

    // Load-use: lw x5 in EX, sub x6,x5,x1 in ID.
    do_reset();
    present(LwX5, 32'h200, 32'h40, 32'h0);
    step();
    present(SubX6, 32'h204, 32'h11, 32'h22);
    #1;
    check("lu_stall", id_stall, 1);
    step();
    check("lu_bubble_instr", ex_instr, Nop);
    check("lu_bubble_valid", ex_valid, 0);
    exm_we = 1'b1; exm_rd = 5'd5; exm_result = 32'h77;
`ifdef ID_EX_FORWARDING_EN
    #1;
    check("lu_release", id_stall, 0);
    step();
    id_valid = 1'b0; exm_we = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    #1;
    check("lu_sub_instr", ex_instr, SubX6);
    check("lu_sub_rv1",   ex_rv1,   32'hABCD);
    check("lu_sub_rv2",   ex_rv2,   32'h22);
`else
    #1;
    check("lu_mem_stall", id_stall, 1);
    step();
    check("lu_mem_bubble", ex_instr, Nop);
    exm_we = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCD;
    #1;
    check("lu_wb_stall", id_stall, 1);
    step();
    check("lu_wb_bubble", ex_instr, Nop);
    wb_we = 1'b0;
    #1;
    check("lu_release", id_stall, 0);
    step();
    id_valid = 1'b0;
    #1;
    check("lu_sub_instr", ex_instr, SubX6);
    check("lu_sub_pc",    ex_pc,    32'h204);
    check("lu_sub_rv1",   ex_rv1,   32'h11);
`endif

    // Operand selection for add x4,x3,x2 sitting in EX.
    do_reset();
    present(AddX4a, 32'h300, 32'h55, 32'h66);
    step();
    id_valid = 1'b0;
    exm_we = 1'b1; exm_rd = 5'd3; exm_result = 32'h10;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h20;
    #1;
`ifdef ID_EX_FORWARDING_EN
    check("fwd_exm_prio", ex_rv1, 32'h10);
    check("fwd_rv2_keep", ex_rv2, 32'h66);
    exm_we = 1'b0;
    #1;
    check("fwd_wb", ex_rv1, 32'h20);
    exm_we = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
    #1;
    check("fwd_x0", ex_rv1, 32'h55);
    wb_rd = 5'd2;
    #1;
    check("fwd_rv2_wb", ex_rv2, 32'h20);
`else
    check("nofwd_rv1", ex_rv1, 32'h55);
    wb_rd = 5'd2;
    #1;
    check("nofwd_rv2", ex_rv2, 32'h66);
`endif

    // Non-load writer in EX followed by a dependent add x4,x3,x3.
    do_reset();
    present(AddX3, 32'h400, 32'h1, 32'h2);
    step();
    present(AddX4b, 32'h404, 32'h9, 32'h9);
`ifdef ID_EX_FORWARDING_EN
    #1;
    check("dep_no_stall", id_stall, 0);
    step();
    check("dep_capture", ex_instr, AddX4b);
`else
    for (int k = 0; k < 4; k++) begin
      exm_we = (k == 1); exm_rd = 5'd3;
      wb_we  = (k == 2); wb_rd  = 5'd3;
      #1;
      check($sformatf("dep_stall%0d", k), id_stall, (k < 3) ? 32'd1 : 32'd0);
      step();
      check($sformatf("dep_ex%0d", k), ex_instr, (k < 3) ? Nop : AddX4b);
    end
`endif

    // Reset in the middle of a load-use hazard discards the ID instruction.
    do_reset();
    present(LwX5, 32'h500, 32'h40, 32'h0);
    step();
    present(SubX6, 32'h504, 32'h11, 32'h22);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", id_stall, 0);
    step();
    reset = 1'b0;
    id_valid = 1'b0;
    #1;
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_instr", ex_instr, Nop);
    check("mid_rst_pc",    ex_pc,    0);
    check("mid_rst_rv1",   ex_rv1,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
